// File: rtl/mem_access_ctrl.sv
// Memory access controller: latches a single read/write command from the control unit and
// handshakes with a variable-latency memory. Optional `MEM_TIMEOUT_EN` adds an abort on missing ack.
module mem_access_ctrl #(
    parameter int ADDR_W  = 9,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       mar_q,
    input  logic [DATA_W-1:0] mdr_q,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_req,
    output logic              mem_we,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mdata_in,
    output logic              mdata_valid,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        dbg_state
);

    // Handshake: mem_req stays high for the whole ACCESS phase; the memory completes it by
    // raising mem_ack for one cycle (read data valid in that same cycle). Acks seen while
    // mem_req is low are ignored.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_mdata;
    logic              r_req;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic              r_mdata_valid;

    logic              w_unused_mar;
    assign w_unused_mar = ^mar_q[31:ADDR_W];

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
    logic [7:0]        r_wait_cnt;
    logic              r_err;
    assign err = r_err;
`else
    logic              w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_mdata       <= '0;
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mdata_valid <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            r_wait_cnt    <= '0;
            r_err         <= 1'b0;
`endif
        end else begin
            r_done        <= 1'b0;
            r_mdata_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (read || write) begin
                        r_addr  <= mar_q[ADDR_W-1:0];
                        // read wins when both are high; the write data is then not latched
                        if (!read) begin
                            r_wdata <= mdr_q;
                        end
                        r_we    <= !read;
                        r_req   <= 1'b1;
                        r_busy  <= 1'b1;
                        r_state <= S_ACCESS;
`ifdef MEM_TIMEOUT_EN
                        r_err      <= 1'b0;
                        r_wait_cnt <= '0;
`endif
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        if (!r_we) begin
                            r_mdata       <= mem_rdata;
                            r_mdata_valid <= 1'b1;
                        end
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
`ifdef MEM_TIMEOUT_EN
                    else if (r_wait_cnt == TIMEOUT_CNT) begin
                        r_err   <= 1'b1;
                        r_req   <= 1'b0;
                        r_we    <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
`endif
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;
    assign mem_req     = r_req;
    assign mem_we      = r_we;
    assign mdata_in    = r_mdata;
    assign mdata_valid = r_mdata_valid;
    assign busy        = r_busy;
    assign done        = r_done;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: bench-side memory array and per-transaction expectations,
// directed cases from the test plan followed by randomized commands.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] mar_q = '0;
    logic [31:0] mdr_q = '0;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_req;
    logic        mem_we;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mdata_in;
    logic        mdata_valid;
    logic        busy;
    logic        done;
    logic        err;
    logic [1:0]  dbg_state;

    mem_access_ctrl #(.ADDR_W(9), .DATA_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .clr_n(clr_n), .read(read), .write(write),
        .mar_q(mar_q), .mdr_q(mdr_q),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mdata_in(mdata_in), .mdata_valid(mdata_valid),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] mem_model [512];
    logic [31:0] exp_q [$];
    logic [31:0] exp_mdata = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge while the DUT is idle; returns at the falling edge of the
    // first idle cycle after completion, so back-to-back calls test cycle-3 acceptance.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wd, input int waits);
        logic [8:0]  a;
        bit          is_rd;
        bit          is_wr;
        a     = addr[8:0];
        is_rd = rd;
        is_wr = wr && !rd;
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_req", {31'd0, mem_req}, 32'd0);
        read    = rd;
        write   = wr;
        mar_q   = addr;
        mdr_q   = wd;
        mem_ack = 1'($urandom_range(0, 1));
        if (is_rd) exp_q.push_back(mem_model[a]);
        @(negedge clk);
        read  = 1'($urandom_range(0, 1));
        write = 1'($urandom_range(0, 1));
        for (int c = 0; c <= waits; c++) begin
            mar_q = $urandom;
            mdr_q = $urandom;
            check("acc_req", {31'd0, mem_req}, 32'd1);
            check("acc_we", {31'd0, mem_we}, {31'd0, is_wr});
            check("acc_addr", {23'd0, mem_addr}, {23'd0, a});
            if (is_wr) check("acc_wdata", mem_wdata, wd);
            check("acc_done", {31'd0, done}, 32'd0);
            check("acc_busy", {31'd0, busy}, 32'd1);
            check("acc_err", {31'd0, err}, 32'd0);
            mem_ack   = (c == waits);
            mem_rdata = (c == waits && is_rd) ? mem_model[a] : $urandom;
            @(negedge clk);
        end
        if (is_wr) mem_model[a] = wd;
        read      = 1'b0;
        write     = 1'b0;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("done_valid", {31'd0, mdata_valid}, {31'd0, is_rd});
        check("done_req", {31'd0, mem_req}, 32'd0);
        check("done_we", {31'd0, mem_we}, 32'd0);
        check("done_busy", {31'd0, busy}, 32'd1);
        check("done_err", {31'd0, err}, 32'd0);
        if (is_rd) begin
            if (exp_q.size() == 0) check("sb_empty", 32'd0, 32'd1);
            else exp_mdata = exp_q.pop_front();
        end
        check("mdata_in", mdata_in, exp_mdata);
        @(negedge clk);
        mem_ack = 1'b0;
        check("post_done", {31'd0, done}, 32'd0);
        check("post_valid", {31'd0, mdata_valid}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 512; i++) mem_model[i] = $urandom;

        #1;
        check("rst_req", {31'd0, mem_req}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_valid", {31'd0, mdata_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_addr", {23'd0, mem_addr}, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_mdata", mdata_in, 32'd0);
        repeat (2) @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);

        // test plan directed cases
        mem_model[9'h010] = 32'hCAFE_0001;
        run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0);
        check("tp_read_mdata", mdata_in, 32'hCAFE_0001);
        run_txn(1'b0, 1'b1, 32'h0000_01FF, 32'h1234_5678, 3);
        check("tp_write_mdata_kept", mdata_in, 32'hCAFE_0001);
        run_txn(1'b1, 1'b1, 32'h0000_01FF, 32'hDEAD_BEEF, 2);
        check("tp_both_read_back", mdata_in, 32'h1234_5678);

        // async reset in the middle of an access
        read  = 1'b1;
        mar_q = 32'h0000_0055;
        @(negedge clk);
        read = 1'b0;
        #2 clr_n = 1'b0;
        #1;
        check("arst_req", {31'd0, mem_req}, 32'd0);
        check("arst_we", {31'd0, mem_we}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_addr", {23'd0, mem_addr}, 32'd0);
        check("arst_mdata", mdata_in, 32'd0);
        exp_mdata = '0;
        exp_q.delete();
        @(negedge clk);
        clr_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("arst_no_done", {31'd0, done}, 32'd0);
            check("arst_no_valid", {31'd0, mdata_valid}, 32'd0);
        end

`ifdef MEM_TIMEOUT_EN
        begin
            int req_cycles;
            bit seen_done;
            read  = 1'b1;
            mar_q = 32'h0000_0033;
            @(negedge clk);
            read       = 1'b0;
            req_cycles = 0;
            seen_done  = 1'b0;
            for (int i = 0; i < 40 && !seen_done; i++) begin
                if (done) seen_done = 1'b1;
                else begin
                    if (mem_req) req_cycles++;
                    @(negedge clk);
                end
            end
            check("to_seen_done", {31'd0, seen_done}, 32'd1);
            check("to_req_cycles", req_cycles, 32'd16);
            check("to_err", {31'd0, err}, 32'd1);
            check("to_valid", {31'd0, mdata_valid}, 32'd0);
            check("to_mdata_kept", mdata_in, exp_mdata);
            @(negedge clk);
            check("to_err_sticky", {31'd0, err}, 32'd1);
            run_txn(1'b1, 1'b0, 32'h0000_0033, 32'h0, 0);
            check("to_err_cleared", {31'd0, err}, 32'd0);
        end
`endif

        for (int t = 0; t < 40; t++) begin
            bit          rd;
            bit          wr;
            logic [31:0] addr;
            rd   = 1'($urandom_range(0, 1));
            wr   = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            addr = {$urandom_range(0, 255), 1'b0, 8'($urandom_range(0, 7))};
            run_txn(rd, wr, addr, $urandom, $urandom_range(0, 12));
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("gap_idle", {31'd0, busy}, 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
